// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - mode encoding and button indices shared by the front-panel controller
package panel_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } mode_t;

    localparam int NBTN      = 5;
    localparam int BTN_TIME  = 0;
    localparam int BTN_ALARM = 1;
    localparam int BTN_MIN   = 2;
    localparam int BTN_HRS   = 3;
    localparam int BTN_ALON  = 4;

endpackage

// File: rtl/panel_ctrl_btn_debounce.sv
// rtl/panel_ctrl_btn_debounce.sv - 2-FF synchroniser, debounce counter and rising-edge press strobe
module btn_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the qualification window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYC - 1)) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/panel_ctrl.sv
// rtl/panel_ctrl.sv - front-panel mode FSM, advance requests and alarm enable
// Optional build macro AUTO_REPEAT_EN adds tick-based auto-repeat on held advance buttons.
import panel_pkg::*;

module panel_ctrl #(
    parameter int DB_CYC    = 16,
    parameter int REP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_time,
    input  logic       btn_alarm,
    input  logic       btn_min,
    input  logic       btn_hrs,
    input  logic       btn_alon,
    output logic       Timeset,
    output logic       Alarmset,
    output logic       Minadv,
    output logic       Hrsadv,
    output logic       Alarmon,
    output logic [1:0] mode
);

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] w_level;
    logic [NBTN-1:0] w_press;
    logic [1:0]      w_adv_press;
    logic [1:0]      w_adv_level;
    logic [1:0]      w_rep;
    logic            w_in_set;
    logic            w_leave;
    logic            w_unused;
    mode_t           w_next;

    mode_t           r_mode;
    logic            r_timeset;
    logic            r_alarmset;
    logic            r_alon;
    logic [1:0]      r_adv;

    assign w_raw = {btn_alon, btn_hrs, btn_min, btn_alarm, btn_time};

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        btn_debounce #(.DB_CYC(DB_CYC)) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (w_raw[g]),
            .level (w_level[g]),
            .press (w_press[g])
        );
    end

    assign w_adv_press = {w_press[BTN_HRS], w_press[BTN_MIN]};
    assign w_adv_level = {w_level[BTN_HRS], w_level[BTN_MIN]};
    assign w_unused    = ^{w_level, 1'(REP_TICKS)};

    always_comb begin
        w_next = r_mode;
        case (r_mode)
            RUN:       if (w_press[BTN_TIME]) w_next = SET_TIME;
                       else if (w_press[BTN_ALARM]) w_next = SET_ALARM;
            SET_TIME:  if (w_press[BTN_TIME]) w_next = RUN;
            SET_ALARM: if (w_press[BTN_ALARM]) w_next = RUN;
            default:   w_next = RUN;
        endcase
    end

    assign w_in_set = (r_mode != RUN);
    assign w_leave  = w_in_set && (w_next == RUN);

`ifdef AUTO_REPEAT_EN
    localparam int RCW = $clog2(REP_TICKS + 1);
    logic [RCW-1:0] r_rcnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_in_set || w_leave || !w_adv_level[i]) r_rcnt[i] <= '0;
                else if (tick && (r_rcnt[i] != RCW'(REP_TICKS))) r_rcnt[i] <= r_rcnt[i] + 1'b1;
            end
        end
    end

    // Re-arm on the tick that brings the count to REP_TICKS, so the next tick already advances.
    always_comb begin
        w_rep = '0;
        for (int i = 0; i < 2; i++) begin
            w_rep[i] = tick && w_in_set && !w_leave && w_adv_level[i] &&
                       (r_rcnt[i] >= RCW'(REP_TICKS - 1));
        end
    end
`else
    assign w_rep = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= RUN;
            r_timeset  <= 1'b0;
            r_alarmset <= 1'b0;
            r_alon     <= 1'b0;
            r_adv      <= '0;
        end else begin
            r_mode     <= w_next;
            r_timeset  <= (w_next == SET_TIME);
            r_alarmset <= (w_next == SET_ALARM);
            if (w_press[BTN_ALON]) r_alon <= ~r_alon;
            if (w_leave) r_adv <= '0;
            else r_adv <= (r_adv & ~{2{tick}}) | (w_in_set ? w_adv_press : 2'b00) | w_rep;
        end
    end

    assign Timeset  = r_timeset;
    assign Alarmset = r_alarmset;
    assign Minadv   = r_adv[0];
    assign Hrsadv   = r_adv[1];
    assign Alarmon  = r_alon;
    assign mode     = r_mode;

endmodule

// File: tb/tb_panel_ctrl.sv
// tb/tb_panel_ctrl.sv - directed and randomized checks of panel_ctrl against an event-level model
`timescale 1ns/1ps
module tb_panel_ctrl;

    localparam int DB  = 16;
    localparam int REP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] btn = '0;
    logic       Timeset, Alarmset, Minadv, Hrsadv, Alarmon;
    logic [1:0] mode;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    int m_mode;
    bit m_min, m_hrs, m_alon;

    panel_ctrl #(.DB_CYC(DB), .REP_TICKS(REP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .btn_time  (btn[0]),
        .btn_alarm (btn[1]),
        .btn_min   (btn[2]),
        .btn_hrs   (btn[3]),
        .btn_alon  (btn[4]),
        .Timeset   (Timeset),
        .Alarmset  (Alarmset),
        .Minadv    (Minadv),
        .Hrsadv    (Hrsadv),
        .Alarmon   (Alarmon),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":mode"},     32'(mode),     32'(m_mode));
        check({tag, ":Timeset"},  32'(Timeset),  32'(m_mode == 1));
        check({tag, ":Alarmset"}, 32'(Alarmset), 32'(m_mode == 2));
        check({tag, ":Minadv"},   32'(Minadv),   32'(m_min));
        check({tag, ":Hrsadv"},   32'(Hrsadv),   32'(m_hrs));
        check({tag, ":Alarmon"},  32'(Alarmon),  32'(m_alon));
    endtask

    task automatic model_reset();
        m_mode = 0; m_min = 0; m_hrs = 0; m_alon = 0;
    endtask

    // Presses in one cycle act on the mode held before that cycle.
    task automatic model_press(input logic [4:0] mask);
        int old;
        old = m_mode;
        if (old != 0) begin
            if (mask[2]) m_min = 1;
            if (mask[3]) m_hrs = 1;
        end
        if (mask[4]) m_alon = !m_alon;
        case (old)
            0: if (mask[0]) m_mode = 1; else if (mask[1]) m_mode = 2;
            1: if (mask[0]) m_mode = 0;
            2: if (mask[1]) m_mode = 0;
            default: m_mode = 0;
        endcase
        if (old != 0 && m_mode == 0) begin
            m_min = 0;
            m_hrs = 0;
        end
    endtask

    task automatic model_tick();
        m_min = 0;
        m_hrs = 0;
    endtask

    task automatic press(input logic [4:0] mask, input string tag);
        btn = btn | mask;
        repeat (DB + 2) @(negedge clk);
        check_all({tag, ":early"});
        @(negedge clk);
        model_press(mask);
        check_all(tag);
        btn = btn & ~mask;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic do_tick(input string tag);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_tick();
        check_all(tag);
    endtask

    initial begin
        model_reset();
        btn   = 5'h1f;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (DB + 2) @(negedge clk);
        check_all("held_rel:early");
        @(negedge clk);
        model_press(5'h1f);
        check_all("held_rel");
        btn = '0;
        repeat (DB + 4) @(negedge clk);

        press(5'b00100, "pend_before_rst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        press(5'b00001, "enter_time");
        for (int i = 0; i < 12; i++) begin
            btn[2] = ~btn[2];
            repeat (5) @(negedge clk);
        end
        check_all("bounce");
        btn[2] = 1'b1;
        repeat (DB + 2) @(negedge clk);
        check_all("bounce_steady:early");
        @(negedge clk);
        model_press(5'b00100);
        check_all("bounce_steady");
        do_tick("bounce_tick");
        repeat (20) @(negedge clk);
        check_all("bounce_hold");
        btn[2] = 1'b0;
        repeat (DB + 4) @(negedge clk);

        press(5'b00001, "fsm_t_exit");
        press(5'b00001, "fsm_t");
        press(5'b00010, "fsm_a_ignored");
        press(5'b00001, "fsm_t_back");
        press(5'b00010, "fsm_a");
        press(5'b00010, "fsm_a_back");
        press(5'b00011, "fsm_both");
        press(5'b00001, "fsm_both_exit");

        press(5'b00010, "adv_alarm");
        press(5'b01000, "adv_hrs");
        do_tick("adv_tick1");
        do_tick("adv_tick2");
        do_tick("adv_tick3");
        press(5'b00010, "adv_exit");
        press(5'b00100, "min_in_run");
        do_tick("run_tick");

        press(5'b10000, "alon1");
        do_tick("alon_tick");
        press(5'b10000, "alon2");

        press(5'b00001, "coinc_enter");
        press(5'b00100, "coinc_pend");
        btn[2] = 1'b1;
        repeat (DB + 2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_tick();
        model_press(5'b00100);
        check_all("coinc");
        btn[2] = 1'b0;
        repeat (DB + 4) @(negedge clk);
        check_all("coinc_wait");
        do_tick("coinc_tick");

        press(5'b01100, "exit_pend");
        press(5'b00001, "exit_clear");

`ifdef AUTO_REPEAT_EN
        press(5'b00001, "rep_enter");
        btn[2] = 1'b1;
        repeat (DB + 3) @(negedge clk);
        m_min = 1;
        check_all("rep_press");
        for (int t = 1; t <= 6; t++) begin
            check("rep_before_tick", 32'(Minadv), 32'((t == 1) || (t - 1 >= REP)));
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn[2] = 1'b0;
        repeat (DB + 4) @(negedge clk);
        check("rep_after_release", 32'(Minadv), 32'(6 >= REP));
        do_tick("rep_final_tick");
        press(5'b00001, "rep_exit");
`endif

        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r <= 4) press(5'(1 << r), "rnd_press");
            else if (r == 5) press(5'b00011, "rnd_both");
            else do_tick("rnd_tick");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
